// File: rtl/axi4_slave_bresp_scheduler_pkg.sv
// Shared types for the AXI4 slave write-response scheduler: response codes, B FSM states
// and the queued completion entry.
package axi4_slave_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    B_IDLE  = 1'b0,
    B_VALID = 1'b1
  } bstate_t;

  localparam int unsigned B_ID_WIDTH = 4;

  typedef struct packed {
    logic [B_ID_WIDTH-1:0] id;
    resp_t                 resp;
  } b_entry_t;

endpackage

// File: rtl/axi4_slave_bresp_scheduler_if.sv
// Completion-in and AXI B-out signal bundle; slave modport is the scheduler's view.
interface axi4_slave_bresp_scheduler_if #(
  parameter int ID_WIDTH = 4
) ();
  import axi4_slave_pkg::*;

  logic                cmpl_valid;
  logic                cmpl_ready;
  logic [ID_WIDTH-1:0] cmpl_id;
  resp_t               cmpl_status;
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] bid;
  resp_t               bresp;

  modport slave (
    input  cmpl_valid, cmpl_id, cmpl_status, bready,
    output cmpl_ready, bvalid, bid, bresp
  );

  modport master (
    output cmpl_valid, cmpl_id, cmpl_status, bready,
    input  cmpl_ready, bvalid, bid, bresp
  );

endinterface

// File: rtl/axi4_slave_bresp_scheduler_fifo.sv
// Synchronous completion queue (axi4_bresp_fifo); DEPTH must be a power of two so the
// pointers wrap naturally. Push while full and pop while empty are ignored.
module axi4_bresp_fifo
  import axi4_slave_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = b_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     wdata,
  input  logic                       pop,
  output entry_t                     rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  entry_t        mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/axi4_slave_bresp_scheduler.sv
// AXI4 slave B-channel scheduler: queues write completions and issues them in order.
// Optional B-stall watchdog enabled by defining AXI4_BRESP_TIMEOUT_EN.
module axi4_slave_bresp_scheduler
  import axi4_slave_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 4,
  parameter int TO_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  axi4_slave_bresp_scheduler_if.slave  bus,
  output logic [$clog2(DEPTH+2)-1:0]   outstanding,
  output logic                         timeout_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(DEPTH+2);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    resp_t               resp;
  } entry_t;

  if (DEPTH < 2 || TO_WIDTH < 1) begin : g_bad_param
    $error("axi4_slave_bresp_scheduler: DEPTH must be >= 2 and TO_WIDTH >= 1");
  end

  bstate_t       state;
  entry_t        out_r;
  logic          bvalid_r;
  entry_t        head;
  entry_t        wentry;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic          push;
  logic          pop;

  assign wentry = '{id: bus.cmpl_id, resp: bus.cmpl_status};
  assign push   = bus.cmpl_valid && !q_full;
  // Reload the output register whenever it is free or being accepted this cycle.
  assign pop    = !q_empty && ((state == B_IDLE) || bus.bready);

  axi4_bresp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= B_IDLE;
      bvalid_r <= 1'b0;
      out_r    <= '0;
    end else begin
      case (state)
        B_IDLE: begin
          if (!q_empty) begin
            out_r    <= head;
            bvalid_r <= 1'b1;
            state    <= B_VALID;
          end
        end
        B_VALID: begin
          if (bus.bready) begin
            if (!q_empty) begin
              out_r <= head;
            end else begin
              bvalid_r <= 1'b0;
              state    <= B_IDLE;
            end
          end
        end
        default: begin
          bvalid_r <= 1'b0;
          state    <= B_IDLE;
        end
      endcase
    end
  end

  assign bus.cmpl_ready = !q_full;
  assign bus.bvalid     = bvalid_r;
  assign bus.bid        = out_r.id;
  assign bus.bresp      = out_r.resp;
  assign outstanding    = OW'(q_count) + OW'(bvalid_r);

`ifdef AXI4_BRESP_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt;
  logic [TO_WIDTH-1:0] to_cnt_nxt;
  logic                to_err_r;

  always_comb begin
    to_cnt_nxt = '0;
    if (bvalid_r && !bus.bready) begin
      to_cnt_nxt = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt   <= '0;
      to_err_r <= 1'b0;
    end else begin
      to_cnt <= to_cnt_nxt;
      if (to_cnt_nxt == '1) to_err_r <= 1'b1;
    end
  end

  assign timeout_err = to_err_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_slave_bresp_scheduler.sv
// Self-checking bench for axi4_slave_bresp_scheduler: directed scenarios plus a randomized
// run against a queue-based reference model of the B-channel rules.
module tb_axi4_slave_bresp_scheduler;
  import axi4_slave_pkg::*;

  localparam int DEPTH    = 4;
  localparam int ID_W     = 4;
  localparam int TO_W     = 4;
`ifdef AXI4_BRESP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } ent_t;

  logic       clk;
  logic       rst;
  logic [2:0] outstanding;
  logic       timeout_err;

  axi4_slave_bresp_scheduler_if #(.ID_WIDTH(ID_W)) bus ();

  axi4_slave_bresp_scheduler #(
    .ID_WIDTH (ID_W),
    .DEPTH    (DEPTH),
    .TO_WIDTH (TO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .outstanding (outstanding),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: completions waiting, plus the response currently presented on B.
  ent_t            mq[$];
  logic            m_bvalid;
  logic [ID_W-1:0] m_bid;
  logic [1:0]      m_bresp;
  int              m_stall;
  logic            m_err;

  task automatic model_step();
    bit   accept;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_bvalid = 1'b0;
      m_bid    = '0;
      m_bresp  = '0;
      m_stall  = 0;
      m_err    = 1'b0;
    end else begin
      accept = bus.cmpl_valid && (mq.size() < DEPTH);
      if (m_bvalid && !bus.bready) begin
        if (m_stall < (1 << TO_W) - 1) m_stall++;
        if (TO_EN && m_stall == (1 << TO_W) - 1) m_err = 1'b1;
      end else begin
        m_stall = 0;
      end
      if (!m_bvalid || bus.bready) begin
        if (mq.size() > 0) begin
          e        = mq.pop_front();
          m_bvalid = 1'b1;
          m_bid    = e.id;
          m_bresp  = e.resp;
        end else begin
          m_bvalid = 1'b0;
        end
      end
      if (accept) begin
        e.id   = bus.cmpl_id;
        e.resp = bus.cmpl_status;
        mq.push_back(e);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_cmpl(input bit v, input int id, input int st);
    bus.cmpl_valid  = v;
    bus.cmpl_id     = ID_W'(id);
    bus.cmpl_status = resp_t'(st[1:0]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_cmpl(0, 0, 0);
    bus.bready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_bad++; $display("FAIL reset_bvalid got %0b exp 0", bus.bvalid); end
    n_cmp++; if (bus.bid !== 4'd0 || bus.bresp !== OKAY) begin n_bad++; $display("FAIL reset_bid_bresp got %0d/%0d exp 0/0", bus.bid, bus.bresp); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    n_cmp++; if (bus.cmpl_ready !== 1'b1 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_ready_err got %0b/%0b exp 1/0", bus.cmpl_ready, timeout_err); end
  endtask

  task automatic test_single();
    bus.bready = 1'b1;
    drive_cmpl(1, 3, 0);
    tick();
    drive_cmpl(0, 0, 0);
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_bad++; $display("FAIL single_early got %0b exp 0", bus.bvalid); end
    tick();
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bid !== 4'd3 || bus.bresp !== OKAY) begin n_bad++; $display("FAIL single_beat got v=%0b id=%0d r=%0d exp 1/3/0", bus.bvalid, bus.bid, bus.bresp); end
    tick();
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_bad++; $display("FAIL single_one_beat got %0b exp 0", bus.bvalid); end
  endtask

  task automatic test_stall();
    bus.bready = 1'b0;
    drive_cmpl(1, 5, 2);
    tick();
    drive_cmpl(0, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (bus.bvalid !== 1'b1 || bus.bid !== 4'd5 || bus.bresp !== SLVERR) begin
        n_bad++; $display("FAIL stall_hold[%0d] got v=%0b id=%0d r=%0d exp 1/5/2", i, bus.bvalid, bus.bid, bus.bresp);
      end
      tick();
    end
    bus.bready = 1'b1;
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bid !== 4'd5) begin n_bad++; $display("FAIL stall_release got v=%0b id=%0d exp 1/5", bus.bvalid, bus.bid); end
    tick();
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_bad++; $display("FAIL stall_done got %0b exp 0", bus.bvalid); end
  endtask

  task automatic test_back_to_back();
    bus.bready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) drive_cmpl(1, k, 0);
      else        drive_cmpl(0, 0, 0);
      tick();
      n_cmp++;
      if (bus.bvalid !== ((k >= 2) && (k <= 5))) begin
        n_bad++; $display("FAIL b2b_valid[%0d] got %0b exp %0b", k, bus.bvalid, (k >= 2) && (k <= 5));
      end else if (bus.bvalid && bus.bid !== 4'(k - 1)) begin
        n_bad++; $display("FAIL b2b_order[%0d] got %0d exp %0d", k, bus.bid, k - 1);
      end
    end
  endtask

  task automatic test_full();
    bus.bready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cmpl(1, 8 + i, i % 4);
      n_cmp++; if (bus.cmpl_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_pre[%0d] got %0b exp 1", i, bus.cmpl_ready); end
      tick();
    end
    n_cmp++; if (bus.cmpl_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %0b exp 0", bus.cmpl_ready); end
    n_cmp++; if (outstanding !== 3'd5) begin n_bad++; $display("FAIL full_outstanding got %0d exp 5", outstanding); end
    drive_cmpl(1, 15, 3);
    tick();
    n_cmp++; if (outstanding !== 3'd5) begin n_bad++; $display("FAIL full_ignore got %0d exp 5", outstanding); end
    drive_cmpl(0, 0, 0);
    bus.bready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.bvalid !== 1'b1 || bus.bid !== 4'(8 + i) || bus.bresp !== 2'(i % 4)) begin
        n_bad++; $display("FAIL full_drain[%0d] got v=%0b id=%0d r=%0d exp 1/%0d/%0d", i, bus.bvalid, bus.bid, bus.bresp, 8 + i, i % 4);
      end
      tick();
    end
    n_cmp++; if (bus.bvalid !== 1'b0 || outstanding !== 3'd0) begin n_bad++; $display("FAIL full_empty got v=%0b out=%0d exp 0/0", bus.bvalid, outstanding); end
  endtask

  task automatic test_reset_mid();
    bus.bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmpl(1, 1 + i, 1);
      tick();
    end
    drive_cmpl(0, 0, 0);
    n_cmp++; if (bus.bvalid !== 1'b1 || outstanding !== 3'd3) begin n_bad++; $display("FAIL rstmid_pre got v=%0b out=%0d exp 1/3", bus.bvalid, outstanding); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.bvalid !== 1'b0 || outstanding !== 3'd0) begin n_bad++; $display("FAIL rstmid_post got v=%0b out=%0d exp 0/0", bus.bvalid, outstanding); end
    bus.bready = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.bvalid !== 1'b0 || bus.cmpl_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_dropped got v=%0b rdy=%0b exp 0/1", bus.bvalid, bus.cmpl_ready); end
  endtask

  task automatic test_timeout();
    bus.bready = 1'b0;
    drive_cmpl(1, 7, 3);
    tick();
    drive_cmpl(0, 0, 0);
    tick();
    n_cmp++; if (bus.bvalid !== 1'b1 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_start got v=%0b err=%0b exp 1/0", bus.bvalid, timeout_err); end
    for (int s = 1; s <= 15; s++) begin
      tick();
      if (s == 14) begin
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_early got %0b exp 0", timeout_err); end
      end
    end
    n_cmp++; if (timeout_err !== TO_EN) begin n_bad++; $display("FAIL to_set got %0b exp %0b", timeout_err, TO_EN); end
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bid !== 4'd7 || bus.bresp !== DECERR) begin n_bad++; $display("FAIL to_held got v=%0b id=%0d r=%0d exp 1/7/3", bus.bvalid, bus.bid, bus.bresp); end
    bus.bready = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.bvalid !== 1'b0 || timeout_err !== TO_EN) begin n_bad++; $display("FAIL to_sticky got v=%0b err=%0b exp 0/%0b", bus.bvalid, timeout_err, TO_EN); end
  endtask

  task automatic test_random();
    logic [2:0] exp_out;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      drive_cmpl(($urandom_range(0, 99) < 55), $urandom_range(0, 15), $urandom_range(0, 3));
      bus.bready = (i % 100 < 50) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 80);
      tick();
      exp_out = 3'(mq.size() + int'(m_bvalid));
      n_cmp++;
      if (bus.bvalid !== m_bvalid) begin
        n_bad++; $display("FAIL rand_bvalid[%0d] got %0b exp %0b", i, bus.bvalid, m_bvalid);
      end else if (m_bvalid && (bus.bid !== m_bid || bus.bresp !== m_bresp)) begin
        n_bad++; $display("FAIL rand_beat[%0d] got id=%0d r=%0d exp %0d/%0d", i, bus.bid, bus.bresp, m_bid, m_bresp);
      end
      n_cmp++; if (outstanding !== exp_out) begin n_bad++; $display("FAIL rand_outstanding[%0d] got %0d exp %0d", i, outstanding, exp_out); end
      n_cmp++; if (bus.cmpl_ready !== (mq.size() < DEPTH)) begin n_bad++; $display("FAIL rand_ready[%0d] got %0b exp %0b", i, bus.cmpl_ready, mq.size() < DEPTH); end
      n_cmp++; if (timeout_err !== m_err) begin n_bad++; $display("FAIL rand_timeout[%0d] got %0b exp %0b", i, timeout_err, m_err); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.bready = 1'b0;
    drive_cmpl(0, 0, 0);
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
